ram_port_master: RTL and testbench

- Initiator side of the single-port synchronous RAM interface.
- Arbitrates between two clients:
  - port A: video fetch, read-only.
  - port B: CPU, read/write.
- Sequences each access onto one RAM port (ce, active-low we, one-cycle registered read latency) and returns data to the client with a req/ack handshake.
- Sits between the CPU/video blocks and the RAM instance in the machine top level.

---
 rtl/ram_port_master_pkg.sv | 12 +
 rtl/ram_port_grant.sv | 26 ++
 rtl/ram_port_master.sv | 129 ++++++++++++
 tb/tb_ram_port_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_master_pkg.sv
// Shared constants for the RAM port master: FSM state encoding and client port ids.
package ram_port_master_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_port_grant.sv
// Combinational winner selection between the video (A) and CPU (B) clients.
module ram_port_grant
  import ram_port_master_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_last,
  output logic o_valid,
  output logic o_port
);

  always_comb begin
    o_valid = i_a_req | i_b_req;
    o_port  = PORT_A;
    if (i_a_req && i_b_req) begin
      // Round-robin hands the contested slot to whichever port did not win last.
      if (RR != 0) o_port = (i_last == PORT_A) ? PORT_B : PORT_A;
      else         o_port = PORT_A;
    end else if (i_b_req) begin
      o_port = PORT_B;
    end
  end

endmodule

// File: rtl/ram_port_master.sv
// Initiator for a single-port synchronous RAM; serves a read-only video port and a
// read/write CPU port with a fixed 4-cycle IDLE/CMD/DATA/ACK access sequence.
module ram_port_master
  import ram_port_master_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int RR = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_ack,
  output logic [DW-1:0] a_q,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_d,
  output logic          b_ack,
  output logic [DW-1:0] b_q,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q,
  output logic [1:0]    dbg_state
);

  // Handshake: a client raises req with its command fields stable and keeps them
  // until its ack; ack is a single-cycle pulse with read data valid alongside it,
  // and the client drops req at the edge that ends the ack cycle.

  logic [1:0]    r_state;
  logic          r_port;
  logic          r_last;
  logic          r_wr;
  logic          r_ce;
  logic          r_we;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_q;
  logic [DW-1:0] r_b_q;

  logic w_valid;
  logic w_port;

  ram_port_grant #(
    .RR(RR)
  ) u_grant (
    .i_a_req(a_req),
    .i_b_req(b_req),
    .i_last (r_last),
    .o_valid(w_valid),
    .o_port (w_port)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_port  <= PORT_A;
      r_last  <= PORT_B;
      r_wr    <= 1'b0;
      r_ce    <= 1'b0;
      r_we    <= 1'b1;
      r_a     <= '0;
      r_d     <= '0;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_a_q   <= '0;
      r_b_q   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_port  <= w_port;
            r_last  <= w_port;
            r_ce    <= 1'b1;
            r_state <= ST_CMD;
            if (w_port == PORT_B) begin
              r_a  <= b_addr;
              r_we <= ~b_wr;
              r_wr <= b_wr;
              if (b_wr) r_d <= b_d;
            end else begin
              r_a  <= a_addr;
              r_we <= 1'b1;
              r_wr <= 1'b0;
            end
          end
        end
        ST_CMD: begin
          r_ce    <= 1'b0;
          r_we    <= 1'b1;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          // Registered RAM output is valid only during this cycle.
          if (!r_wr) begin
            if (r_port == PORT_B) r_b_q <= ram_q;
            else                  r_a_q <= ram_q;
          end
          if (r_port == PORT_B) r_b_ack <= 1'b1;
          else                  r_a_ack <= 1'b1;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a_ack     = r_a_ack;
  assign a_q       = r_a_q;
  assign b_ack     = r_b_ack;
  assign b_q       = r_b_q;
  assign ram_ce    = r_ce;
  assign ram_we    = r_we;
  assign ram_a     = r_a;
  assign ram_d     = r_d;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_port_master.sv
// Bench for ram_port_master: a fixed-priority and a round-robin instance, each with
// its own behavioural RAM, checked against a bench-side memory/arbitration model.
module tb_ram_port_master;
  import ram_port_master_pkg::*;

  logic        clock;
  logic        reset;
  logic        a_req     [2];
  logic [13:0] a_addr    [2];
  logic        a_ack     [2];
  logic [7:0]  a_q       [2];
  logic        b_req     [2];
  logic        b_wr      [2];
  logic [13:0] b_addr    [2];
  logic [7:0]  b_d       [2];
  logic        b_ack     [2];
  logic [7:0]  b_q       [2];
  logic        ram_ce    [2];
  logic        ram_we    [2];
  logic [13:0] ram_a     [2];
  logic [7:0]  ram_d     [2];
  logic [7:0]  ram_q     [2];
  logic [1:0]  dbg_state [2];

  logic [7:0] mem0 [16384];
  logic [7:0] mem1 [16384];

  // Bench model: memory contents, last held read data, last granted port.
  logic [7:0] ref_mem [2][16384];
  logic [7:0] exp_aq [2];
  logic [7:0] exp_bq [2];
  bit         model_last [2];
  logic [8:0] exp_q [$];

  int    n_chk;
  int    n_err;
  string ctx;

  typedef struct {
    int          k;
    bit          port;
    bit          wr;
    logic [13:0] addr;
    logic [7:0]  d;
    logic [7:0]  exp_q;
  } vec_t;
  vec_t tbl [12];

  ram_port_master #(.AW(14), .DW(8), .RR(0)) u_fp (
    .clock(clock), .reset(reset),
    .a_req(a_req[0]), .a_addr(a_addr[0]), .a_ack(a_ack[0]), .a_q(a_q[0]),
    .b_req(b_req[0]), .b_wr(b_wr[0]), .b_addr(b_addr[0]), .b_d(b_d[0]),
    .b_ack(b_ack[0]), .b_q(b_q[0]),
    .ram_ce(ram_ce[0]), .ram_we(ram_we[0]), .ram_a(ram_a[0]), .ram_d(ram_d[0]),
    .ram_q(ram_q[0]), .dbg_state(dbg_state[0])
  );

  ram_port_master #(.AW(14), .DW(8), .RR(1)) u_rr (
    .clock(clock), .reset(reset),
    .a_req(a_req[1]), .a_addr(a_addr[1]), .a_ack(a_ack[1]), .a_q(a_q[1]),
    .b_req(b_req[1]), .b_wr(b_wr[1]), .b_addr(b_addr[1]), .b_d(b_d[1]),
    .b_ack(b_ack[1]), .b_q(b_q[1]),
    .ram_ce(ram_ce[1]), .ram_we(ram_we[1]), .ram_a(ram_a[1]), .ram_d(ram_d[1]),
    .ram_q(ram_q[1]), .dbg_state(dbg_state[1])
  );

  // ---- clock/reset ----
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single-port synchronous RAMs with one-cycle registered read.
  always @(posedge clock) begin
    if (ram_ce[0]) begin
      if (!ram_we[0]) mem0[ram_a[0]] <= ram_d[0];
      else            ram_q[0] <= mem0[ram_a[0]];
    end
    if (ram_ce[1]) begin
      if (!ram_we[1]) mem1[ram_a[1]] <= ram_d[1];
      else            ram_q[1] <= mem1[ram_a[1]];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- checking ----
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%s] actual=0x%0h expected=0x%0h", name, ctx, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int k);
    chk("rst_ram_ce", ram_ce[k], 0);
    chk("rst_ram_we", ram_we[k], 1);
    chk("rst_ram_a", ram_a[k], 0);
    chk("rst_ram_d", ram_d[k], 0);
    chk("rst_a_ack", a_ack[k], 0);
    chk("rst_b_ack", b_ack[k], 0);
    chk("rst_a_q", a_q[k], 0);
    chk("rst_b_q", b_q[k], 0);
    chk("rst_state", dbg_state[k], ST_IDLE);
  endtask

  // ---- driver tasks ----
  task automatic run_single(input int k, input bit port, input bit wr,
                            input logic [13:0] addr, input logic [7:0] d,
                            output logic [7:0] q_seen);
    int lat;
    int ce_cnt;
    bit got;
    bit we_ok;
    bit other_ack;
    lat = 0; ce_cnt = 0; got = 0; we_ok = 1; other_ack = 0; q_seen = '0;
    @(negedge clock);
    if (port == PORT_B) begin
      b_req[k] = 1'b1; b_wr[k] = wr; b_addr[k] = addr; b_d[k] = d;
    end else begin
      a_req[k] = 1'b1; a_addr[k] = addr;
    end
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clock);
      if (ram_ce[k]) begin
        ce_cnt++;
        chk("ram_a", ram_a[k], addr);
        chk("ram_we", ram_we[k], !wr);
        if (wr) chk("ram_d", ram_d[k], d);
      end else if (!ram_we[k]) begin
        we_ok = 0;
      end
      if (port == PORT_B ? a_ack[k] : b_ack[k]) other_ack = 1;
      if (port == PORT_B ? b_ack[k] : a_ack[k]) begin
        got = 1;
        lat = i;
        q_seen = (port == PORT_B) ? b_q[k] : a_q[k];
      end
    end
    a_req[k] = 1'b0;
    b_req[k] = 1'b0;
    chk("ack_seen", got, 1);
    chk("ack_latency", lat, 3);
    chk("ce_cycles", ce_cnt, 1);
    chk("we_high_outside_write", we_ok, 1);
    chk("wrong_port_ack", other_ack, 0);
    if (wr) begin
      ref_mem[k][addr] = d;
    end else begin
      chk("read_data", q_seen, ref_mem[k][addr]);
      if (port == PORT_B) exp_bq[k] = ref_mem[k][addr];
      else                exp_aq[k] = ref_mem[k][addr];
    end
    chk("a_q_hold", a_q[k], exp_aq[k]);
    chk("b_q_hold", b_q[k], exp_bq[k]);
    model_last[k] = port;
  endtask

  // Both clients request continuously (B reads); optionally B keeps requesting after A drops.
  task automatic both_req(input int k, input int n, input logic [13:0] aa,
                          input logic [13:0] ba, input bit keep_b);
    bit          exp_port;
    bit          got;
    int          gap;
    int          total;
    logic [1:0]  seen;
    logic [7:0]  q;
    logic [8:0]  rec;
    exp_q.delete();
    for (int g = 0; g < n; g++) begin
      exp_port = (k == 0) ? PORT_A : ~model_last[k];
      model_last[k] = exp_port;
      exp_q.push_back({exp_port, ref_mem[k][exp_port == PORT_B ? ba : aa]});
    end
    if (keep_b) begin
      model_last[k] = PORT_B;
      exp_q.push_back({PORT_B, ref_mem[k][ba]});
    end
    total = exp_q.size();
    @(negedge clock);
    a_req[k] = 1'b1; a_addr[k] = aa;
    b_req[k] = 1'b1; b_wr[k] = 1'b0; b_addr[k] = ba;
    for (int g = 0; g < total; g++) begin
      got = 0; gap = 0; seen = 2'b00;
      for (int i = 1; i <= 8 && !got; i++) begin
        @(negedge clock);
        if (a_ack[k] || b_ack[k]) begin
          got = 1; gap = i; seen = {a_ack[k], b_ack[k]};
        end
      end
      rec = exp_q.pop_front();
      q = rec[8] ? b_q[k] : a_q[k];
      chk("contend_ack_seen", got, 1);
      chk("contend_ack_spacing", gap, (g == 0) ? 3 : 4);
      chk("contend_grant", seen, rec[8] ? 2'b01 : 2'b10);
      chk("contend_data", q, rec[7:0]);
      if (rec[8]) exp_bq[k] = rec[7:0];
      else        exp_aq[k] = rec[7:0];
      if (g == n - 1) begin
        a_req[k] = 1'b0;
        if (!keep_b) b_req[k] = 1'b0;
      end
    end
    b_req[k] = 1'b0;
    chk("contend_other_q", rec[8] ? a_q[k] : b_q[k], rec[8] ? exp_aq[k] : exp_bq[k]);
  endtask

  // ---- stimulus ----
  logic [7:0]  q_out;
  logic [13:0] pool [16];

  initial begin
    n_chk = 0; n_err = 0; ctx = "init";
    for (int k = 0; k < 2; k++) begin
      a_req[k] = 0; a_addr[k] = '0; b_req[k] = 0; b_wr[k] = 0; b_addr[k] = '0; b_d[k] = '0;
      exp_aq[k] = '0; exp_bq[k] = '0; model_last[k] = PORT_B;
    end
    tbl[0]  = '{0, PORT_B, 1'b1, 14'h0123, 8'h5A, 8'h00};
    tbl[1]  = '{0, PORT_B, 1'b0, 14'h0123, 8'h00, 8'h5A};
    tbl[2]  = '{0, PORT_B, 1'b1, 14'h3FFF, 8'hFF, 8'h00};
    tbl[3]  = '{0, PORT_B, 1'b1, 14'h0000, 8'h11, 8'h00};
    tbl[4]  = '{0, PORT_B, 1'b0, 14'h3FFF, 8'h00, 8'hFF};
    tbl[5]  = '{0, PORT_B, 1'b0, 14'h0000, 8'h00, 8'h11};
    tbl[6]  = '{0, PORT_B, 1'b1, 14'h0010, 8'hA1, 8'h00};
    tbl[7]  = '{0, PORT_B, 1'b1, 14'h0020, 8'hB2, 8'h00};
    tbl[8]  = '{1, PORT_B, 1'b1, 14'h0010, 8'hC3, 8'h00};
    tbl[9]  = '{1, PORT_B, 1'b1, 14'h0020, 8'hD4, 8'h00};
    tbl[10] = '{1, PORT_A, 1'b0, 14'h0010, 8'h00, 8'hC3};
    tbl[11] = '{0, PORT_A, 1'b0, 14'h0123, 8'h00, 8'h5A};

    reset = 1'b1;
    repeat (2) @(negedge clock);
    ctx = "reset";
    chk_reset_vals(0);
    chk_reset_vals(1);
    reset = 1'b0;

    for (int r = 0; r < 12; r++) begin
      ctx = $sformatf("table row %0d", r);
      run_single(tbl[r].k, tbl[r].port, tbl[r].wr, tbl[r].addr, tbl[r].d, q_out);
      if (!tbl[r].wr) chk("table_q", q_out, tbl[r].exp_q);
    end

    ctx = "fixed priority contention";
    both_req(0, 3, 14'h0010, 14'h0020, 1'b1);
    ctx = "round robin contention";
    both_req(1, 4, 14'h0010, 14'h0020, 1'b0);

    // Reset during the DATA cycle of an A read abandons it without an ack.
    ctx = "reset mid access";
    @(negedge clock);
    a_req[0] = 1'b1; a_addr[0] = 14'h0010;
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    a_req[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_aq[k] = '0; exp_bq[k] = '0; model_last[k] = PORT_B;
    end
    @(negedge clock);
    chk("no_ack_in_reset", a_ack[0], 0);
    reset = 1'b0;
    @(negedge clock);
    chk("no_ack_after_reset", a_ack[0], 0);
    ctx = "re-request after reset";
    run_single(0, PORT_A, 1'b0, 14'h0010, 8'h00, q_out);
    chk("rereq_data", q_out, 8'hA1);

    // Randomized traffic against the model memory on both instances.
    for (int k = 0; k < 2; k++) begin
      ctx = $sformatf("random fill inst %0d", k);
      for (int i = 0; i < 16; i++) begin
        pool[i] = 14'($urandom_range(0, 16383));
        run_single(k, PORT_B, 1'b1, pool[i], 8'($urandom_range(0, 255)), q_out);
      end
      ctx = $sformatf("random ops inst %0d", k);
      for (int i = 0; i < 40; i++) begin
        bit p;
        bit w;
        p = 1'($urandom_range(0, 1));
        w = (p == PORT_B) ? 1'($urandom_range(0, 1)) : 1'b0;
        run_single(k, p, w, pool[$urandom_range(0, 15)], 8'($urandom_range(0, 255)), q_out);
      end
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
